// File: rtl/ahb_pkg.sv
// Shared AHB types and constants for the slave memory: transfer/burst enums,
// response encodings and the slave FSM state enum.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        NON_SEQ = 2'b10,
        SEQ     = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
    } hburst_t;

    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    // State names carry a prefix so they do not collide with htrans_t literals
    typedef enum logic [1:0] {
        ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2
    } slv_state_t;

endpackage

// File: rtl/ahb_slave_sram.sv
// 256x32 storage: synchronous write, combinational read, no reset on contents.
module ahb_slave_sram (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0] mem [256];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a 1 KiB word memory with ROM/range/size error checks.
// Optional wait states are compiled in when AHB_SLAVE_WAIT_EN is defined.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int SLAVE_ID     = 0,
    parameter int NO_OF_SLAVES = 2,
    parameter int ROM_LIMIT    = 3,
    parameter int WAIT_CYCLES  = 1
) (
    input  logic        HCLK,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    slv_state_t  state, state_nxt;
    logic        accept, err, to_wait, ready, resp, complete, we;
    logic        dp_valid, dp_write;
    logic [7:0]  dp_idx;
    logic [31:0] rdata_q, mem_rdata, rd_data;
    logic        byp_hit;
    logic [7:0]  byp_idx;
    logic [31:0] byp_data;
    logic        unused_ok;

    assign unused_ok = ^{HBURST, 32'(SLAVE_ID), 32'(WAIT_CYCLES)};

    assign accept = HSEL && HREADYIN && ready &&
                    (htrans_t'(HTRANS) == NON_SEQ || htrans_t'(HTRANS) == SEQ);
    assign err    = (HADDR >= 32'(1024 * NO_OF_SLAVES)) ||
                    (HWRITE && HADDR[9:0] <= 10'(ROM_LIMIT)) ||
                    (HSIZE != HSIZE_WORD);

`ifdef AHB_SLAVE_WAIT_EN
    logic [2:0] wcnt;
    assign to_wait = (WAIT_CYCLES != 0);

    always_ff @(posedge HCLK or negedge reset) begin
        if (!reset)                     wcnt <= 3'd0;
        else if (accept && !err && to_wait) wcnt <= 3'(WAIT_CYCLES);
        else if (state == ST_WAIT)      wcnt <= wcnt - 3'd1;
    end
`else
    assign to_wait = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b1;
        resp      = HRESP_OKAY;
        case (state)
            ST_IDLE, ST_ERR2: begin
                if (state == ST_ERR2) resp = HRESP_ERROR;
                if (accept)      state_nxt = err ? ST_ERR1 : (to_wait ? ST_WAIT : ST_IDLE);
                else             state_nxt = ST_IDLE;
            end
            ST_ERR1: begin
                ready     = 1'b0;
                resp      = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            ST_WAIT: begin
                ready = 1'b0;
`ifdef AHB_SLAVE_WAIT_EN
                if (wcnt <= 3'd1) state_nxt = ST_IDLE;
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // An OKAY data phase completes in the first ready cycle after acceptance
    assign complete = dp_valid && ready;
    assign we       = complete && dp_write;

    always_ff @(posedge HCLK or negedge reset) begin
        if (!reset) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= 8'd0;
            rdata_q  <= 32'd0;
            byp_hit  <= 1'b0;
            byp_idx  <= 8'd0;
            byp_data <= 32'd0;
        end else begin
            if (ready) begin
                dp_valid <= accept && !err;
                if (accept) begin
                    dp_write <= HWRITE;
                    dp_idx   <= HADDR[9:2];
                end
            end
            if (complete && !dp_write) rdata_q <= rd_data;
            byp_hit <= we;
            if (we) begin
                byp_idx  <= dp_idx;
                byp_data <= HWDATA;
            end
        end
    end

    assign rd_data   = (byp_hit && byp_idx == dp_idx) ? byp_data : mem_rdata;
    assign HRDATA    = (complete && !dp_write) ? rd_data : rdata_q;
    assign HREADYOUT = ready;
    assign HRESP     = resp;

    ahb_slave_sram u_sram (
        .clk   (HCLK),
        .we    (we),
        .addr  (dp_idx),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench for ahb_slave_mem: pipelined AHB master driving directed
// and random transfers, checked against a word-array reference model.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    localparam int WC = 2;
`ifdef AHB_SLAVE_WAIT_EN
    localparam int EXP_WAIT = WC;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        HCLK = 1'b0, reset = 1'b0;
    logic        HSEL = 1'b0, HWRITE = 1'b0;
    logic [31:0] HADDR = 32'd0, HWDATA = 32'd0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE = 3'b010, HBURST = 3'b000;
    logic [31:0] HRDATA;
    logic        HREADYOUT, HRESP;

    always #5 HCLK = ~HCLK;

    ahb_slave_mem #(.SLAVE_ID(0), .NO_OF_SLAVES(2), .ROM_LIMIT(3), .WAIT_CYCLES(WC)) dut (
        .HCLK(HCLK), .reset(reset), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HREADYIN(HREADYOUT), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       q[$];
    logic [31:0] mdl [256];
    bit          known [256];

    function automatic bit is_real(input xfer_t x);
        return x.sel && x.trans[1];
    endfunction

    function automatic bit is_err(input xfer_t x);
        return (x.addr >= 32'd2048) || (x.wr && x.addr[9:0] <= 10'd3) || (x.size != 3'b010);
    endfunction

    task automatic push(input bit sel, input logic [1:0] tr, input logic [31:0] a,
                        input bit wr, input logic [31:0] d, input logic [2:0] sz);
        xfer_t x;
        x.sel = sel; x.trans = tr; x.addr = a; x.wr = wr; x.wdata = d; x.size = sz;
        q.push_back(x);
    endtask

    // Runs the queue as a pipelined master; HREADYIN follows HREADYOUT
    task automatic run_q();
        xfer_t d_it, a_it, idle_it;
        bit    d_act = 0;
        int    stall = 0;
        logic  rdy, rsp;
        logic [31:0] rd;
        bit    e, r, has_a;
        idle_it.sel = 0; idle_it.trans = 2'b00; idle_it.addr = 0;
        idle_it.wr = 0; idle_it.size = 3'b010; idle_it.wdata = 0;
        while (q.size() > 0 || d_act) begin
            rdy = HREADYOUT; rsp = HRESP; rd = HRDATA;
            has_a = q.size() > 0;
            a_it  = has_a ? q[0] : idle_it;
            HSEL = a_it.sel; HTRANS = a_it.trans; HADDR = a_it.addr;
            HWRITE = a_it.wr; HSIZE = a_it.size;
            HWDATA = d_act ? d_it.wdata : 32'h0;
            if (d_act) begin
                r = is_real(d_it);
                e = r && is_err(d_it);
                if (!rdy) begin
                    stall++;
                    chk("stall_resp", 32'(rsp), 32'(e));
                    if (stall > 20) begin
                        n_chk++; n_fail++;
                        $display("FAIL timeout: data phase stalled %0d cycles, limit 20", stall);
                        q.delete();
                        return;
                    end
                end else begin
                    chk("wait_cycles", 32'(stall), e ? 32'd1 : (r ? 32'(EXP_WAIT) : 32'd0));
                    chk("resp", 32'(rsp), 32'(e));
                    if (r && !e) begin
                        if (d_it.wr) begin
                            mdl[d_it.addr[9:2]]   = d_it.wdata;
                            known[d_it.addr[9:2]] = 1;
                        end else if (known[d_it.addr[9:2]]) begin
                            chk("rdata", rd, mdl[d_it.addr[9:2]]);
                        end else begin
                            mdl[d_it.addr[9:2]]   = rd;
                            known[d_it.addr[9:2]] = 1;
                        end
                    end
                end
            end
            @(posedge HCLK); #1;
            if (rdy) begin
                d_it  = a_it;
                d_act = has_a;
                if (has_a) void'(q.pop_front());
                stall = 0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        @(negedge HCLK) reset = 1'b1;
        @(posedge HCLK); #1;

        // single write then read back
        push(1, NON_SEQ, 32'h10, 1, 32'hDEAD_BEEF, 3'b010);
        push(1, NON_SEQ, 32'h10, 0, 32'h0, 3'b010);
        // ROM write error leaves word 0 intact
        push(1, NON_SEQ, 32'h0, 0, 32'h0, 3'b010);
        push(1, NON_SEQ, 32'h2, 1, 32'h1234_5678, 3'b010);
        push(1, NON_SEQ, 32'h0, 0, 32'h0, 3'b010);
        // out-of-range read, bad size, then recovery
        push(1, NON_SEQ, 32'h900, 0, 32'h0, 3'b010);
        push(1, NON_SEQ, 32'h20, 0, 32'h0, 3'b001);
        push(1, NON_SEQ, 32'h10, 0, 32'h0, 3'b010);
        run_q();

        HBURST = INCR4;
        for (int i = 0; i < 4; i++)
            push(1, i == 0 ? NON_SEQ : SEQ, 32'h100 + 32'(4 * i), 1, 32'hA5A5_0000 + 32'(i), 3'b010);
        for (int i = 0; i < 4; i++)
            push(1, i == 0 ? NON_SEQ : SEQ, 32'h100 + 32'(4 * i), 0, 32'h0, 3'b010);
        run_q();
        HBURST = SINGLE;

        // back-to-back read-after-write with idle/busy/unselected cycles around it
        push(1, NON_SEQ, 32'h200, 1, 32'hCAFE_F00D, 3'b010);
        push(1, NON_SEQ, 32'h200, 0, 32'h0, 3'b010);
        push(1, IDLE, 32'h200, 1, 32'h0, 3'b010);
        push(1, BUSY, 32'h204, 0, 32'h0, 3'b010);
        push(0, NON_SEQ, 32'h200, 1, 32'h1111_1111, 3'b010);
        push(1, NON_SEQ, 32'h200, 0, 32'h0, 3'b010);
        run_q();

        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 19);
            logic [31:0] a;
            a = 32'($urandom_range(0, 31)) * 4 + ($urandom_range(0, 1) == 1 ? 32'd1024 : 32'd0);
            if (r == 0) a = 32'h800 + ($urandom & 32'h0000_FFFC);
            push($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), a,
                 $urandom_range(0, 1) == 1, $urandom, r == 1 ? 3'b000 : 3'b010);
        end
        run_q();

        // reset in the middle of a write data phase: the write must be dropped
        push(1, NON_SEQ, 32'h300, 1, 32'h0BAD_CAFE, 3'b010);
        push(1, NON_SEQ, 32'h300, 0, 32'h0, 3'b010);
        run_q();
        HSEL = 1; HTRANS = NON_SEQ; HADDR = 32'h300; HWRITE = 1; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HTRANS = IDLE; HWDATA = 32'h7777_7777;
        #2 reset = 1'b0;
        #1;
        chk("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("midrst_hresp", 32'(HRESP), 32'd0);
        chk("midrst_hrdata", HRDATA, 32'd0);
        @(negedge HCLK) reset = 1'b1;
        @(posedge HCLK); #1;
        push(1, NON_SEQ, 32'h300, 0, 32'h0, 3'b010);
        run_q();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 Parameter SLAVE_ID, default 0, meaning slave index; the slave owns byte range [SLAVE_ID*1024, SLAVE_ID*1024+1023].
REQ-002 Parameter NO_OF_SLAVES, default 2, meaning total slaves; the legal system address limit is 1024*NO_OF_SLAVES.
REQ-003 Parameter ROM_LIMIT, default 3, meaning any write with HADDR[9:0] <= ROM_LIMIT targets read-only space.
REQ-004 Parameter WAIT_CYCLES, default 1, range 0..7, meaning wait states per OKAY transfer (REQ-024 only).
REQ-005 HCLK  input  1  bus clock; all logic on posedge.
REQ-006 reset  input  1  asynchronous, active-low reset; one clock only.
REQ-007 HSEL  input  1  slave select from decoder.
REQ-008 HADDR  input  32  byte address.
REQ-009 HWRITE  input  1  1=write, 0=read.
REQ-010 HTRANS  input  2  IDLE/BUSY/NON_SEQ/SEQ.
REQ-011 HSIZE  input  3  transfer size; only word (3'b010) is legal.
REQ-012 HBURST  input  3  burst type; accepted, not used for addressing.
REQ-013 HWDATA  input  32  write data, valid in data phase.
REQ-014 HREADYIN  input  1  bus-level HREADY; previous transfer completes when high.
REQ-015 HRDATA  output  32  read data.
REQ-016 HREADYOUT  output  1  slave ready.
REQ-017 HRESP  output  1  0=OKAY, 1=ERROR.

Function
REQ-018 A transfer is accepted on a posedge where HSEL=1, HREADYIN=1 and HTRANS is NON_SEQ or SEQ; its HADDR/HWRITE/HSIZE are registered as the data-phase control.
REQ-019 IDLE or BUSY with HSEL=1, or HSEL=0, yields a zero-wait OKAY data phase (HREADYOUT=1, HRESP=0), with no memory access.
REQ-020 Error condition is evaluated at acceptance: HADDR >= 1024*NO_OF_SLAVES, or HWRITE=1 with HADDR[9:0] <= ROM_LIMIT, or HSIZE != 3'b010.
REQ-021 Error response is two cycles: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1. An errored write does not modify memory.
REQ-022 State machine states: IDLE, WAIT, ERR1, ERR2.
- IDLE to ERR1 on an accepted error transfer.
- IDLE to WAIT on an accepted OKAY transfer when wait states are enabled and WAIT_CYCLES > 0.
- Otherwise IDLE stays in IDLE.
- ERR1 to ERR2; ERR2 to IDLE, or to ERR1/WAIT if a new transfer is accepted in ERR2.
REQ-023 OKAY write: the memory word HADDR[9:2] is written with HWRITE data in the data-phase cycle where HREADYOUT=1; read: HRDATA is valid in the cycle where HREADYOUT=1, and holds its last value otherwise.
REQ-024 In WAIT, HREADYOUT=0 and HRESP=0 for exactly WAIT_CYCLES cycles, counted by a 3-bit down-counter; the data phase completes on the next cycle.
REQ-025 Read-after-write to the same word in back-to-back transfers returns the new HWDATA (bypass), not the stale array contents.
REQ-026 Address and control stay unchanged while HREADYOUT=0; the slave samples address/control only at acceptance.
REQ-027 HSEL deasserted mid data phase does not abort the current data phase.

Reset
REQ-028 While reset=0: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0, data-phase control cleared. Memory contents are not reset.
REQ-029 Reset asserted mid-transfer abandons that transfer; a pending write is not committed.

Configuration
REQ-030 AHB_SLAVE_WAIT_EN defined: the WAIT state and counter are compiled in, and OKAY transfers take WAIT_CYCLES+1 data-phase cycles.
REQ-031 AHB_SLAVE_WAIT_EN undefined: no WAIT state; every OKAY transfer is zero-wait and WAIT_CYCLES is ignored.

Structure
REQ-032 Shared package ahb_pkg holds:
- the htrans_t enum (IDLE=2'b00, BUSY=2'b01, NON_SEQ=2'b10, SEQ=2'b11);
- the hburst_t enum (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16);
- HRESP_OKAY/HRESP_ERROR constants and the slave FSM state enum.
REQ-033 One sub-module, ahb_slave_sram: 256x32 synchronous-write, combinational-read array.

Verification
REQ-034 Single write 0x0000_0010 data 0xDEAD_BEEF, then read 0x10 -> write completes with HREADYOUT=1, HRESP=0; read returns 0xDEAD_BEEF.
REQ-035 Write to 0x0000_0002 -> cycle 1 HREADYOUT=0/HRESP=1, cycle 2 HREADYOUT=1/HRESP=1; a later read of 0x0 returns the pre-write value.
REQ-036 Read of 0x0000_0900 (>= 2048) -> two-cycle ERROR; FSM returns to IDLE.
REQ-037 INCR4 write at 0x100 (NON_SEQ then 3 SEQ), then INCR4 read -> 4 OKAY beats; data matches and address increments by 4.
REQ-038 With AHB_SLAVE_WAIT_EN and WAIT_CYCLES=2, a single read -> HREADYOUT low for 2 cycles, then high with valid data.
REQ-039 Reset asserted during WAIT -> outputs return to their reset values immediately; the aborted write is absent on read-back.
